corelet_seq: RTL and testbench

- Parametrised sequencer that runs one complete convolution layer through the corelet datapath: L0, PE array, OFIFO and SFU.
- For each kernel position it:
  - fetches `col` weight vectors from activation/weight SRAM into L0 and loads them into the PE array;
  - streams `num_x` activation vectors through L0 in execute mode;
  - drains OFIFO rows into the SFU/psum memory, accumulating across kernel positions.
- Sits between the testbench/host `start` interface and the corelet control ports; replaces hand-driven instruction sequences.

---
 rtl/corelet_seq.sv | 181 ++++++++++++++++++
 tb/tb_corelet_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_seq.sv
// Layer sequencer for the corelet datapath. For each kernel position it fills
// and loads weights, streams activations, and drains OFIFO rows to psum memory.
module corelet_seq #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int AW     = 11,
   parameter int XW     = 7,
   parameter int KW     = 4,
   parameter int W_BASE = 0,
   parameter int X_BASE = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [XW-1:0] num_x,
   input  logic [KW-1:0] num_k,
   input  logic          relu_en,
   output logic          busy,
   output logic          done,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   output logic          l0_wr,
   output logic          l0_rd,
   input  logic          l0_ready,
   output logic [2:0]    inst_w,
   input  logic          ofifo_valid,
   output logic          ofifo_rd,
   output logic          psum_wr,
   output logic [XW-1:0] psum_addr,
   output logic          sfp_acc,
   output logic          sfp_mode
);

   localparam int CW = $clog2(col + 1);
   localparam int NW = (XW > CW) ? XW : CW;
   localparam int LW = $clog2(col + row + 1);

   typedef enum logic [2:0] {IDLE, W_FILL, W_LOAD, X_STREAM, DRAIN, DONE} state_t;

   state_t        state, next;
   logic [KW-1:0] k, nk;
   logic [XW-1:0] nx;
   logic [NW-1:0] nx_n;
   logic [NW-1:0] issue_cnt, exec_cnt, rd_cnt, occ;
   logic [LW-1:0] load_cnt;
   logic          relu;

   assign nx_n      = NW'(nx);
   assign psum_wr   = ofifo_rd;
   assign psum_addr = rd_cnt[XW-1:0];
   assign sfp_mode  = relu;

   always_comb begin
      next     = state;
      busy     = 1'b0;
      done     = 1'b0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      l0_rd    = 1'b0;
      inst_w   = 3'b000;
      ofifo_rd = 1'b0;
      sfp_acc  = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next = (num_x != '0 && num_k != '0) ? W_FILL : DONE;
         end
         W_FILL: begin
            busy = 1'b1;
            if (issue_cnt < NW'(col)) begin
               mem_rd   = l0_ready;
               mem_addr = AW'(W_BASE) + AW'(k * col) + AW'(issue_cnt);
            end else begin
               // issue_cnt reaches col the cycle the final l0_wr lands
               next = W_LOAD;
            end
         end
         W_LOAD: begin
            busy = 1'b1;
            if (load_cnt < LW'(col)) begin
               l0_rd  = 1'b1;
               inst_w = 3'b001;
            end
            if (load_cnt == LW'(col + row - 1))
               next = X_STREAM;
         end
         X_STREAM: begin
            busy = 1'b1;
            if (issue_cnt < nx_n) begin
               mem_rd   = l0_ready;
               mem_addr = AW'(X_BASE) + AW'(issue_cnt);
            end
            if (occ != '0 && exec_cnt < nx_n) begin
               l0_rd  = 1'b1;
               inst_w = 3'b010;
            end
            ofifo_rd = ofifo_valid && (rd_cnt < nx_n);
            sfp_acc  = (k != '0);
            if (exec_cnt == nx_n)
               next = DRAIN;
         end
         DRAIN: begin
            busy     = 1'b1;
            ofifo_rd = ofifo_valid && (rd_cnt < nx_n);
            sfp_acc  = (k != '0);
            if (rd_cnt == nx_n)
               next = (k == nk - KW'(1)) ? DONE : W_FILL;
         end
         DONE: begin
            done = 1'b1;
            next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         k         <= '0;
         nk        <= '0;
         nx        <= '0;
         relu      <= 1'b0;
         issue_cnt <= '0;
         exec_cnt  <= '0;
         rd_cnt    <= '0;
         occ       <= '0;
         load_cnt  <= '0;
         l0_wr     <= 1'b0;
      end else begin
         state <= next;
         l0_wr <= mem_rd;
         if (l0_wr && !l0_rd)
            occ <= occ + NW'(1);
         else if (!l0_wr && l0_rd)
            occ <= occ - NW'(1);
         case (state)
            IDLE: begin
               if (start) begin
                  nx        <= num_x;
                  nk        <= num_k;
                  relu      <= relu_en;
                  k         <= '0;
                  issue_cnt <= '0;
                  exec_cnt  <= '0;
                  rd_cnt    <= '0;
               end
            end
            W_FILL: begin
               if (mem_rd)
                  issue_cnt <= issue_cnt + NW'(1);
               if (next == W_LOAD) begin
                  issue_cnt <= '0;
                  load_cnt  <= '0;
               end
            end
            W_LOAD: load_cnt <= load_cnt + LW'(1);
            X_STREAM: begin
               if (mem_rd)
                  issue_cnt <= issue_cnt + NW'(1);
               if (l0_rd)
                  exec_cnt <= exec_cnt + NW'(1);
               if (ofifo_rd)
                  rd_cnt <= rd_cnt + NW'(1);
            end
            DRAIN: begin
               if (ofifo_rd)
                  rd_cnt <= rd_cnt + NW'(1);
               if (next == W_FILL) begin
                  k         <= k + KW'(1);
                  issue_cnt <= '0;
                  exec_cnt  <= '0;
                  rd_cnt    <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_corelet_seq.sv
// Self-checking bench for corelet_seq: L0/OFIFO behavioural models feed the DUT,
// expected read addresses and psum writes come from per-layer reference queues.
module tb_corelet_seq;

   localparam int ROW = 8, COL = 8, AW = 11, XW = 7, KW = 4;
   localparam int W_BASE = 0, X_BASE = 1024, L0_DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset, start, relu_en, l0_ready, ofifo_valid;
   logic [XW-1:0] num_x;
   logic [KW-1:0] num_k;
   logic          busy, done, mem_rd, l0_wr, l0_rd, ofifo_rd, psum_wr, sfp_acc, sfp_mode;
   logic [AW-1:0] mem_addr;
   logic [2:0]    inst_w;
   logic [XW-1:0] psum_addr;
   logic [AW+XW+11:0] outs;

   always #5 clk = ~clk;

   corelet_seq #(.row(ROW), .col(COL), .AW(AW), .XW(XW), .KW(KW),
                 .W_BASE(W_BASE), .X_BASE(X_BASE)) dut (
      .clk(clk), .reset(reset), .start(start), .num_x(num_x), .num_k(num_k),
      .relu_en(relu_en), .busy(busy), .done(done), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_ready(l0_ready),
      .inst_w(inst_w), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
      .psum_wr(psum_wr), .psum_addr(psum_addr), .sfp_acc(sfp_acc), .sfp_mode(sfp_mode)
   );

   assign outs = {busy, done, mem_rd, mem_addr, l0_wr, l0_rd, inst_w,
                  ofifo_rd, psum_wr, psum_addr, sfp_acc, sfp_mode};

   int n_tests = 0, n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference queues: read addresses in issue order, psum writes encoded as row*2+acc
   int exp_addr[$];
   int exp_psum[$];

   task automatic plan_layer(input int nx, input int nk);
      if (nx == 0 || nk == 0) return;
      for (int kk = 0; kk < nk; kk++) begin
         for (int i = 0; i < COL; i++) exp_addr.push_back((W_BASE + kk * COL + i) % (1 << AW));
         for (int j = 0; j < nx; j++) exp_addr.push_back((X_BASE + j) % (1 << AW));
         for (int j = 0; j < nx; j++) exp_psum.push_back(j * 2 + ((kk != 0) ? 1 : 0));
      end
   endtask

   int cyc = 0, done_cnt = 0, exec_m = 0, load_m = 0, psum_cnt = 0, acc1_cnt = 0;
   int ld_run = 0, last_ld_cyc = 0, first_x_cyc = 0;
   int stall_wr = 0, stall_rd = 0, l0_occ = 0, of_pend = 0;
   int cap_rst, cap_wr, cap_rd, cap_ex, cap_ofrd;
   bit x_pending = 0, last_mr = 0, prev_mr = 0, gate = 1;
   bit stall = 0, rnd_stall_en = 0, toggle_en = 0;
   int last_addr = 0;

   // monitor at negedge, input models update shortly after posedge
   initial begin
      l0_ready = 1'b1;
      ofifo_valid = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         check_eq("l0_wr_lag", l0_wr, prev_mr);
         check_eq("l0_rd_vs_inst", l0_rd, inst_w != 3'b000);
         check_eq("psum_wr_vs_ofrd", psum_wr, ofifo_rd);
         if (mem_rd) begin
            check_eq("rd_while_not_ready", l0_ready, 1);
            check_eq("rd_expected", exp_addr.size() != 0, 1);
            if (exp_addr.size() != 0) check_eq("mem_addr", mem_addr, exp_addr.pop_front());
         end
         if (ofifo_rd) begin
            check_eq("ofrd_valid", ofifo_valid, 1);
            check_eq("psum_expected", exp_psum.size() != 0, 1);
            if (exp_psum.size() != 0) begin
               int e;
               e = exp_psum.pop_front();
               check_eq("psum_addr", psum_addr, e / 2);
               check_eq("sfp_acc", sfp_acc, e % 2);
            end
            psum_cnt++;
            acc1_cnt += int'(sfp_acc);
         end
         if (l0_rd) check_eq("l0_underflow", l0_occ > 0, 1);
         if (inst_w == 3'b001) begin
            ld_run++; load_m++; last_ld_cyc = cyc; x_pending = 1;
         end else begin
            if (ld_run != 0) check_eq("load_run_len", ld_run, COL);
            ld_run = 0;
         end
         if (inst_w == 3'b010) exec_m++;
         if (mem_rd && mem_addr >= AW'(X_BASE) && x_pending) begin
            first_x_cyc = cyc; x_pending = 0;
         end
         if (done) begin
            done_cnt++;
            check_eq("busy_at_done", busy, 0);
         end
         if (stall) begin
            stall_wr += int'(l0_wr); stall_rd += int'(mem_rd);
         end
         last_mr = mem_rd; last_addr = int'(mem_addr);
         cap_rst = int'(reset); cap_wr = int'(l0_wr); cap_rd = int'(l0_rd);
         cap_ex = int'(inst_w == 3'b010); cap_ofrd = int'(ofifo_rd);
         prev_mr = reset ? mem_rd : 1'b0;
         @(posedge clk); #2;
         if (cap_rst == 0) begin
            l0_occ = 0; of_pend = 0;
         end else begin
            l0_occ += cap_wr - cap_rd;
            of_pend += cap_ex - cap_ofrd;
         end
         gate = toggle_en ? ~gate : 1'b1;
         l0_ready = (L0_DEPTH - l0_occ >= 2) && !stall &&
                    !(rnd_stall_en && $urandom_range(0, 3) == 0);
         ofifo_valid = (of_pend > 0) && gate;
      end
   end

   int base_done, base_exec, base_load, base_psum, base_acc1;
   bit cur_relu;

   task automatic launch(input int nx, input int nk, input bit relu);
      plan_layer(nx, nk);
      base_done = done_cnt; base_exec = exec_m; base_load = load_m;
      base_psum = psum_cnt; base_acc1 = acc1_cnt;
      @(posedge clk); #1;
      start = 1'b1; num_x = XW'(nx); num_k = KW'(nk); relu_en = relu; cur_relu = relu;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == base_done && n < budget) begin
         @(posedge clk);
         n++;
      end
      check_eq("done_in_budget", done_cnt != base_done, 1);
   endtask

   task automatic finish_layer(input int nx, input int nk);
      int good;
      good = (nx > 0 && nk > 0) ? 1 : 0;
      repeat (3) @(negedge clk);
      check_eq("done_once", done_cnt - base_done, 1);
      check_eq("busy_after", busy, 0);
      check_eq("addr_left", exp_addr.size(), 0);
      check_eq("psum_left", exp_psum.size(), 0);
      check_eq("exec_total", exec_m - base_exec, good * nx * nk);
      check_eq("load_total", load_m - base_load, good * COL * nk);
      check_eq("psum_total", psum_cnt - base_psum, good * nx * nk);
      check_eq("acc1_total", acc1_cnt - base_acc1, good * nx * (nk - 1));
      check_eq("sfp_mode", sfp_mode, cur_relu);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nx, nk, n;
      reset = 1'b0; start = 1'b1; num_x = 16; num_k = 1; relu_en = 1'b1;
      repeat (3) begin
         @(posedge clk); @(negedge clk);
         check_eq("reset_outs", outs, 0);
      end
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b0;
      @(negedge clk);
      check_eq("idle_busy", busy, 0);

      // single position, with a start poke while busy
      launch(16, 1, 1'b1);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check_eq("busy_after_start", busy, 1);
      repeat (20) @(posedge clk);
      #1 start = 1'b1; num_x = 5; num_k = 2; relu_en = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      wait_done(3000);
      finish_layer(16, 1);
      check_eq("load_to_x_gap", first_x_cyc - last_ld_cyc, ROW + 1);

      // multi position, toggling ofifo_valid, explicit L0 stall
      toggle_en = 1;
      launch(36, 9, 1'b0);
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (!(last_mr && last_addr >= X_BASE + 3) && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check_eq("stall_trigger", n < 2000, 1);
      #1 stall = 1; stall_wr = 0; stall_rd = 0;
      repeat (5) @(posedge clk);
      #1 stall = 0;
      check_eq("stall_trailing_wr", stall_wr, 1);
      check_eq("stall_rd", stall_rd, 0);
      wait_done(20000);
      finish_layer(36, 9);
      check_eq("acc0_count", (psum_cnt - base_psum) - (acc1_cnt - base_acc1), 36);

      // start held high across the whole layer including DONE
      rnd_stall_en = 1;
      nx = $urandom_range(1, 20); nk = $urandom_range(1, 3);
      launch(nx, nk, 1'($urandom_range(0, 1)));
      wait_done(10000);
      #1 start = 1'b0;
      finish_layer(nx, nk);

      // degenerate starts
      for (int d = 0; d < 2; d++) begin
         launch((d == 0) ? 0 : 5, (d == 0) ? 3 : 0, 1'(d));
         @(negedge clk);
         check_eq("degen_done_early", done, 0);
         @(posedge clk); #1 start = 1'b0;
         @(negedge clk);
         check_eq("degen_done", done, 1);
         check_eq("degen_busy", busy, 0);
         @(negedge clk);
         check_eq("degen_done_clear", done, 0);
         finish_layer((d == 0) ? 0 : 5, (d == 0) ? 3 : 0);
      end

      // random layers
      for (int r = 0; r < 3; r++) begin
         nx = $urandom_range(1, 40); nk = $urandom_range(1, 4);
         launch(nx, nk, 1'($urandom_range(0, 1)));
         @(posedge clk); #1 start = 1'b0;
         wait_done(10000);
         finish_layer(nx, nk);
      end

      // reset in the middle of X_STREAM, then a fresh layer
      rnd_stall_en = 0; toggle_en = 0;
      launch(16, 1, 1'b1);
      @(posedge clk); #1 start = 1'b0;
      repeat (29) @(posedge clk);
      check_eq("mid_x_reached", x_pending, 0);
      #1 reset = 1'b0;
      @(posedge clk); @(negedge clk);
      check_eq("abort_outs", outs, 0);
      @(posedge clk); @(negedge clk);
      check_eq("abort_outs_hold", outs, 0);
      @(posedge clk); #1;
      exp_addr.delete(); exp_psum.delete();
      reset = 1'b1;
      launch(16, 2, 1'b0);
      @(posedge clk); #1 start = 1'b0;
      wait_done(5000);
      finish_layer(16, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
